// File: rtl/bus_pkg.sv
// Shared codes and types for the Mini SRC bus transfer sequencer.
package bus_pkg;

  // Select value that leaves the bus undriven.
  localparam logic [4:0] SEL_NONE = 5'b11111;

  // Highest legal source/destination code.
  localparam int MAX_CODE = 22;

  // Source codes (bus mux code space).
  localparam logic [4:0] SRC_R0    = 5'd0;
  localparam logic [4:0] SRC_R1    = 5'd1;
  localparam logic [4:0] SRC_R2    = 5'd2;
  localparam logic [4:0] SRC_R3    = 5'd3;
  localparam logic [4:0] SRC_R4    = 5'd4;
  localparam logic [4:0] SRC_R5    = 5'd5;
  localparam logic [4:0] SRC_R6    = 5'd6;
  localparam logic [4:0] SRC_R7    = 5'd7;
  localparam logic [4:0] SRC_R8    = 5'd8;
  localparam logic [4:0] SRC_R9    = 5'd9;
  localparam logic [4:0] SRC_R10   = 5'd10;
  localparam logic [4:0] SRC_R11   = 5'd11;
  localparam logic [4:0] SRC_R12   = 5'd12;
  localparam logic [4:0] SRC_R13   = 5'd13;
  localparam logic [4:0] SRC_R14   = 5'd14;
  localparam logic [4:0] SRC_R15   = 5'd15;
  localparam logic [4:0] SRC_HI    = 5'd16;
  localparam logic [4:0] SRC_LO    = 5'd17;
  localparam logic [4:0] SRC_ZHIGH = 5'd18;
  localparam logic [4:0] SRC_ZLOW  = 5'd19;
  localparam logic [4:0] SRC_PC    = 5'd20;
  localparam logic [4:0] SRC_MDR   = 5'd21;
  localparam logic [4:0] SRC_IR    = 5'd22;

  // Destination codes; load_en bit k strobes destination code k.
  localparam logic [4:0] DST_R0    = 5'd0;
  localparam logic [4:0] DST_R1    = 5'd1;
  localparam logic [4:0] DST_R2    = 5'd2;
  localparam logic [4:0] DST_R3    = 5'd3;
  localparam logic [4:0] DST_R4    = 5'd4;
  localparam logic [4:0] DST_R5    = 5'd5;
  localparam logic [4:0] DST_R6    = 5'd6;
  localparam logic [4:0] DST_R7    = 5'd7;
  localparam logic [4:0] DST_R8    = 5'd8;
  localparam logic [4:0] DST_R9    = 5'd9;
  localparam logic [4:0] DST_R10   = 5'd10;
  localparam logic [4:0] DST_R11   = 5'd11;
  localparam logic [4:0] DST_R12   = 5'd12;
  localparam logic [4:0] DST_R13   = 5'd13;
  localparam logic [4:0] DST_R14   = 5'd14;
  localparam logic [4:0] DST_R15   = 5'd15;
  localparam logic [4:0] DST_HI    = 5'd16;
  localparam logic [4:0] DST_LO    = 5'd17;
  localparam logic [4:0] DST_Y     = 5'd18;
  localparam logic [4:0] DST_MAR   = 5'd19;
  localparam logic [4:0] DST_PC    = 5'd20;
  localparam logic [4:0] DST_MDR   = 5'd21;
  localparam logic [4:0] DST_IR    = 5'd22;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/bus_load_ctrl_if.sv
// Request handshake and bus-control outputs of the transfer sequencer.
interface bus_load_ctrl_if #(
  parameter int SEL_W   = 5,
  parameter int NUM_DST = 23
);
  logic               req_valid;
  logic               req_ready;
  logic [SEL_W-1:0]   req_src;
  logic [SEL_W-1:0]   req_dst;
  logic [SEL_W-1:0]   reg_out_select;
  logic [NUM_DST-1:0] load_en;
  logic               busy;
  logic               err;

  // Requester side: issues transfers, observes bus control.
  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, reg_out_select, load_en, busy, err
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, reg_out_select, load_en, busy, err
  );
endinterface

// File: rtl/bus_load_ctrl_xfer_fifo.sv
// Small synchronous request FIFO; pointers wrap modulo DEPTH, storage is not reset.
module xfer_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Next pointer/count/storage values; a push and pop together leave count unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; clearing flushes the queue.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bus_load_ctrl.sv
// Mini SRC bus transfer sequencer: queues src->dst transfers, drives the bus
// mux select for one cycle to settle, then strobes exactly one load enable.
module bus_load_ctrl
  import bus_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SEL_W   = 5,
  parameter int NUM_DST = 23
) (
  input  logic          clock,
  input  logic          clear_n,
  bus_load_ctrl_if.slave bus
);
  localparam logic [SEL_W-1:0] MAX_C    = SEL_W'(MAX_CODE);
  localparam logic [SEL_W-1:0] SEL_IDLE = SEL_W'(SEL_NONE);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   cur_src_q, cur_src_d;
  logic [SEL_W-1:0]   cur_dst_q, cur_dst_d;
  logic               err_q, err_d;

  logic               codes_ok;
  logic               accept;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2*SEL_W-1:0] fifo_dout;
  logic [SEL_W-1:0]   head_src;
  logic [SEL_W-1:0]   head_dst;
  logic [SEL_W-1:0]   sel_out;
  logic [NUM_DST-1:0] load_out;

  // Out-of-range codes still complete the handshake but never enter the queue.
  assign codes_ok  = (bus.req_src <= MAX_C) && (bus.req_dst <= MAX_C);
  assign accept    = bus.req_valid && !fifo_full;
  assign fifo_push = accept && codes_ok;
  assign head_src  = fifo_dout[2*SEL_W-1:SEL_W];
  assign head_dst  = fifo_dout[SEL_W-1:0];

  xfer_fifo #(
    .WIDTH (2*SEL_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .clear_n (clear_n),
    .push    (fifo_push),
    .din     ({bus.req_src, bus.req_dst}),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sequencer next state: pop into the current-transfer register on IDLE/LOAD exit.
  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          cur_src_d = head_src;
          cur_dst_d = head_dst;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        state_d = LOAD;
      end
      LOAD: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          cur_src_d = head_src;
          cur_dst_d = head_dst;
          state_d   = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Rejection pulse for the cycle after an out-of-range request is taken.
  always_comb begin
    err_d = accept && !codes_ok;
  end

  // Control flops; reset drops the in-flight transfer immediately.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Current-transfer codes; only observed outside IDLE, so left unreset.
  always_ff @(posedge clock) begin
    cur_src_q <= cur_src_d;
    cur_dst_q <= cur_dst_d;
  end

  // Bus outputs decoded from registered state only.
  always_comb begin
    sel_out  = SEL_IDLE;
    load_out = '0;
    if (state_q != IDLE) begin
      sel_out = cur_src_q;
    end
    if (state_q == LOAD) begin
      load_out = NUM_DST'(1) << cur_dst_q;
    end
  end

  assign bus.req_ready      = !fifo_full;
  assign bus.reg_out_select = sel_out;
  assign bus.load_en        = load_out;
  assign bus.busy           = !fifo_empty || (state_q != IDLE);
  assign bus.err            = err_q;

endmodule

// File: tb/tb_bus_load_ctrl.sv
// Directed bench for bus_load_ctrl: single transfers, back-pressure burst,
// rejected codes and asynchronous clear during LOAD.
module tb_bus_load_ctrl;
  logic clock;
  logic clear_n;

  bus_load_ctrl_if #(.SEL_W(5), .NUM_DST(23)) bif ();

  bus_load_ctrl #(
    .DEPTH   (4),
    .SEL_W   (5),
    .NUM_DST (23)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] onehot(input int k);
    logic [31:0] one;
    one = 32'd1;
    return one << k;
  endfunction

  // One transfer from an idle sequencer, checked cycle by cycle.
  task automatic run_single(input logic [4:0] s, input logic [4:0] d);
    @(negedge clock);
    chk("pre_sel", 32'(bif.reg_out_select), 32'h1f);
    chk("pre_busy", 32'(bif.busy), 32'd0);
    bif.req_valid = 1'b1;
    bif.req_src   = s;
    bif.req_dst   = d;
    @(negedge clock);
    bif.req_valid = 1'b0;
    chk("n_sel", 32'(bif.reg_out_select), 32'h1f);
    chk("n_load", 32'(bif.load_en), 32'd0);
    chk("n_busy", 32'(bif.busy), 32'd1);
    @(negedge clock);
    chk("n1_sel", 32'(bif.reg_out_select), 32'(s));
    chk("n1_load", 32'(bif.load_en), 32'd0);
    @(negedge clock);
    chk("n2_sel", 32'(bif.reg_out_select), 32'(s));
    chk("n2_load", 32'(bif.load_en), onehot(int'(d)));
    chk("n2_busy", 32'(bif.busy), 32'd1);
    @(negedge clock);
    chk("n3_sel", 32'(bif.reg_out_select), 32'h1f);
    chk("n3_load", 32'(bif.load_en), 32'd0);
    chk("n3_busy", 32'(bif.busy), 32'd0);
  endtask

  int acc_it[$];
  int ld_it[$];
  logic [31:0] ld_val[$];
  logic [31:0] ld_sel[$];
  int exp_acc[9] = '{0, 1, 2, 3, 4, 5, 6, 8, 10};

  initial begin
    int k;
    logic [31:0] any_load;

    clear_n       = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_src   = '0;
    bif.req_dst   = '0;
    #1;
    chk("rst_sel", 32'(bif.reg_out_select), 32'h1f);
    chk("rst_load", 32'(bif.load_en), 32'd0);
    chk("rst_ready", 32'(bif.req_ready), 32'd1);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_err", 32'(bif.err), 32'd0);
    repeat (2) @(negedge clock);
    clear_n = 1'b1;

    // PC -> MAR, then same-register transfer R5 -> R5
    run_single(5'd20, 5'd19);
    run_single(5'd5, 5'd5);

    // Rejected source code
    @(negedge clock);
    bif.req_valid = 1'b1;
    bif.req_src   = 5'd25;
    bif.req_dst   = 5'd3;
    @(negedge clock);
    bif.req_valid = 1'b0;
    chk("bad_err", 32'(bif.err), 32'd1);
    chk("bad_busy", 32'(bif.busy), 32'd0);
    chk("bad_load", 32'(bif.load_en), 32'd0);
    @(negedge clock);
    chk("bad_err_drop", 32'(bif.err), 32'd0);
    chk("bad_busy1", 32'(bif.busy), 32'd0);
    chk("bad_sel1", 32'(bif.reg_out_select), 32'h1f);
    @(negedge clock);
    chk("bad_load2", 32'(bif.load_en), 32'd0);

    // Burst of 9 with valid held: FIFO fills, loads every other cycle
    k = 0;
    for (int it = 0; it < 24; it++) begin
      @(negedge clock);
      if (bif.load_en != '0) begin
        ld_it.push_back(it);
        ld_val.push_back(32'(bif.load_en));
        ld_sel.push_back(32'(bif.reg_out_select));
      end
      if (k < 9) begin
        bif.req_valid = 1'b1;
        bif.req_src   = 5'(20 - k);
        bif.req_dst   = 5'(k + 1);
        if (bif.req_ready) begin
          acc_it.push_back(it);
          k++;
        end
      end else begin
        bif.req_valid = 1'b0;
      end
    end
    bif.req_valid = 1'b0;
    chk("burst_acc_n", 32'(acc_it.size()), 32'd9);
    chk("burst_load_n", 32'(ld_it.size()), 32'd9);
    for (int j = 0; j < 9; j++) begin
      chk("burst_acc_cyc", 32'((acc_it.size() > j) ? acc_it[j] : -1), 32'(exp_acc[j]));
      chk("burst_load_cyc", 32'((ld_it.size() > j) ? ld_it[j] : -1), 32'(3 + 2 * j));
      chk("burst_load_val", (ld_val.size() > j) ? ld_val[j] : 32'hffff_ffff, onehot(j + 1));
      chk("burst_load_sel", (ld_sel.size() > j) ? ld_sel[j] : 32'hffff_ffff, 32'(20 - j));
    end
    chk("burst_idle", 32'(bif.busy), 32'd0);

    // Clear during LOAD with two entries still queued
    for (int it = 0; it < 3; it++) begin
      @(negedge clock);
      bif.req_valid = 1'b1;
      bif.req_src   = 5'(10 + it);
      bif.req_dst   = 5'(it);
    end
    @(negedge clock);
    bif.req_valid = 1'b0;
    chk("clr_pre_load", 32'(bif.load_en), onehot(0));
    chk("clr_pre_sel", 32'(bif.reg_out_select), 32'd10);
    #1;
    clear_n = 1'b0;
    #1;
    chk("clr_load", 32'(bif.load_en), 32'd0);
    chk("clr_sel", 32'(bif.reg_out_select), 32'h1f);
    @(negedge clock);
    clear_n = 1'b1;
    chk("clr_ready", 32'(bif.req_ready), 32'd1);
    chk("clr_busy", 32'(bif.busy), 32'd0);
    any_load = '0;
    for (int it = 0; it < 6; it++) begin
      @(negedge clock);
      any_load = any_load | 32'(bif.load_en);
    end
    chk("clr_no_loads", any_load, 32'd0);
    chk("clr_busy_after", 32'(bif.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
